// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
    logic        we;
  } cmd_t;

  // Bit positions inside spi_status
  localparam int unsigned STAT_TIMEOUT  = 0;
  localparam int unsigned STAT_OVERFLOW = 1;
  localparam int unsigned STAT_PENDING  = 2;

  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hEE;

endpackage

// File: rtl/spi_bridge_sync.sv
// Two-flop synchroniser for the asynchronous SPI select (busy) plus a
// single-cycle falling-edge pulse marking the end of an SPI transaction.
module spi_bridge_sync (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic busy_fall
);

  logic busy_meta;
  logic busy_s;
  logic busy_d;

  // Synchronise busy and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
      busy_d    <= 1'b0;
    end else begin
      busy_meta <= busy;
      busy_s    <= busy_meta;
      busy_d    <= busy_s;
    end
  end

  assign busy_fall = busy_d & ~busy_s;

endmodule

// File: rtl/spi_bus_bridge.sv
// Bridge from the SPI slave core byte stream to the req/ack register bus.
// Each rx_valid becomes one single-byte bus transaction; read data returns
// on tx_valid/tx_data. A one-entry skid buffer absorbs a command arriving
// while the bus is busy. Optional bus timeout: define SPI_BRIDGE_TIMEOUT_EN.
module spi_bus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic [23:0] address,
  input  logic        we,
  input  logic        rx_valid,
  input  logic        busy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [7:0]  spi_status,
  output logic [23:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_req,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata
);

  state_t state;
  logic   busy_fall;

  cmd_t   cap_cmd;
  logic   cap_valid;
  cmd_t   skid_cmd;
  logic   skid_valid;

  logic   abort_q;
  logic   aborted;
  logic   ovf_q;
  logic   to_q;
  logic   to_expire;
  logic   to_set;
  logic   ovf_set;

  logic   issue;
  cmd_t   issue_cmd;
  logic   cap_to_skid;

  spi_bridge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .busy_fall (busy_fall)
  );

  // Configurations below 2 cycles leave no room for the counter to run
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_too_small
  end

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Down-counter armed on every bus request, stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (issue) begin
      to_cnt <= TO_LOAD;
    end else if ((state == S_REQ) && (to_cnt != '0)) begin
      to_cnt <= to_cnt - TO_W'(1);
    end
  end

  assign to_expire = (state == S_REQ) && (to_cnt == '0);
`else
  assign to_expire = 1'b0;
`endif

  // Command routing: skid entry has priority; a capture seen while the skid
  // is being drained in S_IDLE takes the freed slot, so nothing is lost
  always_comb begin
    issue       = (state == S_IDLE) && (skid_valid || cap_valid);
    issue_cmd   = skid_valid ? skid_cmd : cap_cmd;
    cap_to_skid = cap_valid && ((state != S_IDLE) || skid_valid);
    ovf_set     = cap_valid && (state != S_IDLE) && skid_valid;
    to_set      = (state == S_REQ) && !bus_ack && to_expire;
    aborted     = abort_q || busy_fall;
  end

  // Capture register and one-entry skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid  <= 1'b0;
      cap_cmd    <= '0;
      skid_valid <= 1'b0;
      skid_cmd   <= '0;
    end else begin
      cap_valid <= rx_valid;
      if (rx_valid) begin
        cap_cmd <= '{addr: address, data: rx_data, we: we};
      end
      if (busy_fall) begin
        skid_valid <= 1'b0;
      end else if (cap_to_skid && !ovf_set) begin
        skid_valid <= 1'b1;
        skid_cmd   <= cap_cmd;
      end else if (issue && skid_valid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (busy_fall) begin
        ovf_q <= 1'b0;
      end
      if (to_set) begin
        to_q <= 1'b1;
      end else if (busy_fall) begin
        to_q <= 1'b0;
      end
    end
  end

  // Status byte shifted out by the core at the start of each transaction
  always_comb begin
    spi_status                = '0;
    spi_status[STAT_TIMEOUT]  = to_q;
    spi_status[STAT_OVERFLOW] = ovf_q;
    spi_status[STAT_PENDING]  = bus_req;
  end

  // Bus transaction FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      abort_q   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (issue) begin
            bus_req   <= 1'b1;
            bus_addr  <= issue_cmd.addr;
            bus_wdata <= issue_cmd.data;
            bus_we    <= issue_cmd.we;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack in the expiry cycle takes precedence over the timeout
          if (bus_ack || to_expire) begin
            bus_req <= 1'b0;
            abort_q <= 1'b0;
            if (bus_we) begin
              state <= S_IDLE;
            end else begin
              tx_data <= bus_ack ? bus_rdata : ERR_DATA;
              if (aborted) begin
                state <= S_IDLE;
              end else begin
                tx_valid <= 1'b1;
                state    <= S_RESP;
              end
            end
          end else if (busy_fall) begin
            abort_q <= 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed test of spi_bus_bridge: write, read, skid/overflow, abort,
// timeout (or indefinite wait when the timeout option is not built), reset.
module tb_spi_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic [23:0] address;
  logic        we;
  logic        rx_valid;
  logic        busy;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [7:0]  spi_status;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_req;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int tx_pulses = 0;
  int base;

  spi_bus_bridge #(
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (8'hEE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .address    (address),
    .we         (we),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .spi_status (spi_status),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_valid === 1'b1) tx_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] a, input logic [7:0] d, input logic w);
    address  = a;
    rx_data  = d;
    we       = w;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    bus_rdata = d;
    bus_ack   = 1'b1;
    step();
    bus_ack   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; rx_valid = 1'b0; rx_data = '0;
    address = '0; we = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    step(3);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_status", 32'(spi_status), 32'h0);
    check("rst_bus_addr", 32'(bus_addr), 32'h0);
    rst = 1'b0;

    // Write
    busy = 1'b1;
    step(3);
    base = tx_pulses;
    send(24'h000010, 8'h5A, 1'b1);
    step();
    check("wr_req", 32'(bus_req), 32'h1);
    check("wr_addr", 32'(bus_addr), 32'h10);
    check("wr_wdata", 32'(bus_wdata), 32'h5A);
    check("wr_we", 32'(bus_we), 32'h1);
    check("wr_status_pending", 32'(spi_status), 32'h04);
    step(2);
    check("wr_req_held", 32'(bus_req), 32'h1);
    ack(8'h00);
    check("wr_req_drop", 32'(bus_req), 32'h0);
    step(2);
    check("wr_no_tx", 32'(tx_pulses - base), 32'h0);

    // Read
    base = tx_pulses;
    send(24'h000020, 8'h00, 1'b0);
    step();
    check("rd_req", 32'(bus_req), 32'h1);
    check("rd_we", 32'(bus_we), 32'h0);
    check("rd_addr", 32'(bus_addr), 32'h20);
    ack(8'hC3);
    check("rd_tx_valid", 32'(tx_valid), 32'h1);
    check("rd_tx_data", 32'(tx_data), 32'hC3);
    check("rd_req_drop", 32'(bus_req), 32'h0);
    step();
    check("rd_tx_valid_off", 32'(tx_valid), 32'h0);
    check("rd_one_pulse", 32'(tx_pulses - base), 32'h1);

    // Skid and overflow: three writes back to back, ack held low
    address = 24'h000030; rx_data = 8'h11; we = 1'b1; rx_valid = 1'b1;
    step();
    address = 24'h000031; rx_data = 8'h22;
    step();
    address = 24'h000032; rx_data = 8'h33;
    step();
    rx_valid = 1'b0;
    step();
    check("skid_first_addr", 32'(bus_addr), 32'h30);
    check("skid_status_ovf", 32'(spi_status), 32'h06);
    ack(8'h00);
    check("skid_ack_drop", 32'(bus_req), 32'h0);
    step();
    check("skid_second_req", 32'(bus_req), 32'h1);
    check("skid_second_addr", 32'(bus_addr), 32'h31);
    check("skid_second_data", 32'(bus_wdata), 32'h22);
    ack(8'h00);
    step(3);
    check("skid_third_dropped", 32'(bus_req), 32'h0);
    check("skid_status_sticky", 32'(spi_status), 32'h02);
    busy = 1'b0;
    step(2);
    check("ovf_before_clear", 32'(spi_status), 32'h02);
    step();
    check("ovf_cleared", 32'(spi_status), 32'h00);

    // Abort: read on the bus, one command in the skid, then busy falls
    busy = 1'b1;
    step(3);
    base = tx_pulses;
    send(24'h000040, 8'h00, 1'b0);
    step();
    check("abort_req", 32'(bus_req), 32'h1);
    send(24'h000041, 8'h00, 1'b0);
    step();
    busy = 1'b0;
    step(5);
    check("abort_req_held", 32'(bus_req), 32'h1);
    ack(8'h77);
    check("abort_no_tx_valid", 32'(tx_valid), 32'h0);
    check("abort_req_drop", 32'(bus_req), 32'h0);
    step(3);
    check("abort_skid_flushed", 32'(bus_req), 32'h0);
    check("abort_no_pulse", 32'(tx_pulses - base), 32'h0);
    check("abort_status", 32'(spi_status), 32'h00);

    busy = 1'b1;
    step(3);
`ifdef SPI_BRIDGE_TIMEOUT_EN
    // Timeout after 8 cycles of bus_req with no ack
    base = tx_pulses;
    send(24'h000050, 8'h00, 1'b0);
    step();
    check("to_req", 32'(bus_req), 32'h1);
    step(7);
    check("to_req_still_high", 32'(bus_req), 32'h1);
    step();
    check("to_req_drop", 32'(bus_req), 32'h0);
    check("to_tx_valid", 32'(tx_valid), 32'h1);
    check("to_tx_data", 32'(tx_data), 32'hEE);
    check("to_status", 32'(spi_status), 32'h01);
    step();
    check("to_one_pulse", 32'(tx_pulses - base), 32'h1);
    busy = 1'b0;
    step(3);
    check("to_status_cleared", 32'(spi_status), 32'h00);
    busy = 1'b1;
    step(3);
`else
    // Without the timeout option the request waits indefinitely
    send(24'h000050, 8'h00, 1'b0);
    step(12);
    check("nto_req_waits", 32'(bus_req), 32'h1);
    check("nto_status", 32'(spi_status), 32'h04);
    ack(8'h99);
    check("nto_tx_valid", 32'(tx_valid), 32'h1);
    check("nto_tx_data", 32'(tx_data), 32'h99);
    step();
`endif

    // Reset during S_REQ with a command waiting in the skid buffer
    send(24'h000060, 8'h00, 1'b0);
    step();
    check("rstop_req", 32'(bus_req), 32'h1);
    send(24'h000061, 8'h00, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstop_req_drop", 32'(bus_req), 32'h0);
    check("rstop_tx_valid", 32'(tx_valid), 32'h0);
    check("rstop_status", 32'(spi_status), 32'h00);
    step(3);
    check("rstop_skid_empty", 32'(bus_req), 32'h0);
    send(24'h000070, 8'hA5, 1'b1);
    step();
    check("rstop_idle_new_req", 32'(bus_req), 32'h1);
    check("rstop_idle_new_addr", 32'(bus_addr), 32'h70);
    ack(8'h00);
    check("rstop_final_drop", 32'(bus_req), 32'h0);
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
